// File: rtl/tick_gen_pkg.sv
// Shared types and default constants for the tick generator.
package tick_gen_pkg;

  localparam int unsigned DefaultCntW = 16;
  localparam int unsigned DefaultDiv  = 3;

  typedef enum logic [0:0] {
    StIdle,
    StRun
  } tick_state_e;

endpackage

// File: rtl/div_counter.sv
// Divide counter: counts while enabled, wraps to 0 after reaching limit.
// wrap is decoded from the count register and the enable only.
module div_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count up and wrap at limit.
  always_comb begin
    cnt_d = cnt_q;
    wrap  = en && (cnt_q == limit);
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tick_gen_ctrl.sv
// Programmable tick generator with IDLE/RUN control and a shadowed divisor.
// A divisor loaded while running takes effect right after the next tick.
// Build option: define TICK_GEN_CTRL_SQUARE_EN to add the slow_clk output.
module tick_gen_ctrl
  import tick_gen_pkg::*;
#(
  parameter int unsigned CNT_W       = DefaultCntW,
  parameter int unsigned DEFAULT_DIV = DefaultDiv
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             load,
  input  logic [CNT_W-1:0] div_val,
  output logic             load_ready,
  output logic             tick,
  output logic             running,
  output logic [7:0]       tick_count
`ifdef TICK_GEN_CTRL_SQUARE_EN
  ,
  output logic             slow_clk
`endif
);

  tick_state_e      state_q, state_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] shadow_q, shadow_d;
  logic             pending_q, pending_d;
  logic [7:0]       tick_count_q, tick_count_d;
  logic             start_acc, stop_acc, load_acc, cnt_clr, wrap;

  // Control FSM: stop has priority over start.
  always_comb begin
    state_d   = state_q;
    start_acc = 1'b0;
    stop_acc  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start && !stop) begin
          state_d   = StRun;
          start_acc = 1'b1;
        end
      end
      StRun: begin
        if (stop) begin
          state_d  = StIdle;
          stop_acc = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign cnt_clr    = start_acc | stop_acc;
  assign running    = (state_q == StRun);
  assign load_ready = (state_q == StIdle) || !pending_q;
  assign load_acc   = load && load_ready;
  assign tick       = wrap;
  assign tick_count = tick_count_q;

  div_counter #(
    .CNT_W(CNT_W)
  ) u_div_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (cnt_clr),
    .en   (running),
    .limit(div_q),
    .wrap (wrap)
  );

  // Divisor update: direct in IDLE, via shadow in RUN, flushed on stop.
  always_comb begin
    div_d        = div_q;
    shadow_d     = shadow_q;
    pending_d    = pending_q;
    tick_count_d = tick_count_q;
    if (state_q == StIdle) begin
      if (load_acc) begin
        div_d = div_val;
      end
    end else if (stop_acc) begin
      // A load accepted on the stop edge is newest, so it wins over the shadow.
      if (load_acc) begin
        div_d = div_val;
      end else if (pending_q) begin
        div_d = shadow_q;
      end
      pending_d = 1'b0;
    end else begin
      if (wrap && pending_q) begin
        div_d     = shadow_q;
        pending_d = 1'b0;
      end
      // load_acc implies pending_q was clear, so this never clashes with the copy.
      if (load_acc) begin
        shadow_d  = div_val;
        pending_d = 1'b1;
      end
    end
    if (start_acc) begin
      tick_count_d = '0;
    end else if (tick) begin
      tick_count_d = tick_count_q + 8'd1;
    end
  end

  // State and divisor registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StIdle;
      div_q        <= CNT_W'(DEFAULT_DIV);
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      div_q        <= div_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      tick_count_q <= tick_count_d;
    end
  end

`ifdef TICK_GEN_CTRL_SQUARE_EN
  logic slow_q;

  // Square wave: toggle on every tick; used as data only.
  always_ff @(posedge clk) begin
    if (reset) begin
      slow_q <= 1'b0;
    end else if (tick) begin
      slow_q <= ~slow_q;
    end
  end

  assign slow_clk = slow_q;
`endif

endmodule

// File: tb/tb_tick_gen_ctrl.sv
// Directed self-checking bench for tick_gen_ctrl.
module tb_tick_gen_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, stop, load;
  logic [15:0] div_val;
  logic        load_ready, tick, running;
  logic [7:0]  tick_count;
`ifdef TICK_GEN_CTRL_SQUARE_EN
  logic        slow_clk;
`endif

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  tick_gen_ctrl #(
    .CNT_W      (16),
    .DEFAULT_DIV(3)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .load      (load),
    .div_val   (div_val),
    .load_ready(load_ready),
    .tick      (tick),
    .running   (running),
    .tick_count(tick_count)
`ifdef TICK_GEN_CTRL_SQUARE_EN
    ,
    .slow_clk  (slow_clk)
`endif
  );

  // Advance one rising edge and settle.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; load = 1'b0;
  endtask

  // Load a divisor while IDLE.
  task automatic idle_load(input logic [15:0] d);
    load = 1'b1; div_val = d;
    cyc();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stop = 1'b0; load = 1'b1; div_val = 16'd5;
    cyc();
    cyc();
    n_checks++;
    if (tick !== 1'b0) begin n_fails++; $display("FAIL reset_tick: got %b want 0", tick); end
    n_checks++;
    if (running !== 1'b0) begin n_fails++; $display("FAIL reset_running: got %b want 0", running); end
    n_checks++;
    if (load_ready !== 1'b1) begin n_fails++; $display("FAIL reset_ready: got %b want 1", load_ready); end
    n_checks++;
    if (tick_count !== 8'd0) begin n_fails++; $display("FAIL reset_count: got %0d want 0", tick_count); end
    reset = 1'b0;
    idle_inputs();
    cyc();
  endtask

  // Default divisor 3: ticks in cycles 4, 8, 12 after start.
  task automatic test_default_run();
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      n_checks++;
      if (tick !== ((k % 4) == 0)) begin
        n_fails++; $display("FAIL basic_tick c%0d: got %b want %b", k, tick, (k % 4) == 0);
      end
      n_checks++;
      if (tick_count !== 8'((k - 1) / 4)) begin
        n_fails++; $display("FAIL basic_count c%0d: got %0d want %0d", k, tick_count, (k - 1) / 4);
      end
      cyc();
    end
    n_checks++;
    if (tick_count !== 8'd3) begin n_fails++; $display("FAIL basic_count_end: got %0d want 3", tick_count); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++;
    if (running !== 1'b0) begin n_fails++; $display("FAIL basic_stop_running: got %b want 0", running); end
  endtask

  // Divisor 0: tick every RUN cycle, stop drops it next cycle.
  task automatic test_div_zero();
    idle_load(16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      n_checks++;
      if (tick !== 1'b1) begin n_fails++; $display("FAIL div0_tick c%0d: got %b want 1", k, tick); end
      n_checks++;
      if (tick_count !== 8'(k - 1)) begin
        n_fails++; $display("FAIL div0_count c%0d: got %0d want %0d", k, tick_count, k - 1);
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++;
    if (tick !== 1'b0) begin n_fails++; $display("FAIL div0_stop_tick: got %b want 0", tick); end
    n_checks++;
    if (running !== 1'b0) begin n_fails++; $display("FAIL div0_stop_running: got %b want 0", running); end
    cyc();
    n_checks++;
    if (tick_count !== 8'd6) begin n_fails++; $display("FAIL div0_hold_count: got %0d want 6", tick_count); end
  endtask

  // Reload 1 while running with divisor 3; a second load while busy is dropped.
  task automatic test_reload();
    logic [9:0] exp_tick;
    exp_tick = 10'b0101010000; // bit k = expected tick in cycle k
    idle_load(16'd3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    load = 1'b1; div_val = 16'd1;
    cyc();
    n_checks++;
    if (load_ready !== 1'b0) begin n_fails++; $display("FAIL reload_ready_c3: got %b want 0", load_ready); end
    div_val = 16'd0;
    cyc();
    load = 1'b0;
    n_checks++;
    if (load_ready !== 1'b0) begin n_fails++; $display("FAIL reload_ready_c4: got %b want 0", load_ready); end
    for (int k = 4; k <= 9; k++) begin
      n_checks++;
      if (tick !== exp_tick[k]) begin
        n_fails++; $display("FAIL reload_tick c%0d: got %b want %b", k, tick, exp_tick[k]);
      end
      if (k == 5) begin
        n_checks++;
        if (load_ready !== 1'b1) begin n_fails++; $display("FAIL reload_ready_c5: got %b want 1", load_ready); end
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  // Stop while a shadow divisor is pending applies it.
  task automatic test_stop_pending();
    idle_load(16'd3);
    start = 1'b1;
    cyc();
    start = 1'b0;
    load = 1'b1; div_val = 16'd0;
    cyc();
    load = 1'b0;
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    n_checks++;
    if (load_ready !== 1'b1) begin n_fails++; $display("FAIL stoppend_ready: got %b want 1", load_ready); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    n_checks++;
    if (tick !== 1'b1) begin n_fails++; $display("FAIL stoppend_tick: got %b want 1", tick); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  // start and stop together: IDLE, no tick.
  task automatic test_start_stop();
    idle_load(16'd0);
    start = 1'b1; stop = 1'b1;
    cyc();
    n_checks++;
    if (running !== 1'b0 || tick !== 1'b0) begin
      n_fails++; $display("FAIL both_idle: got run=%b tick=%b want 0 0", running, tick);
    end
    stop = 1'b0;
    cyc();
    n_checks++;
    if (running !== 1'b1) begin n_fails++; $display("FAIL both_start: got %b want 1", running); end
    stop = 1'b1;
    cyc();
    idle_inputs();
    n_checks++;
    if (running !== 1'b0 || tick !== 1'b0) begin
      n_fails++; $display("FAIL both_run: got run=%b tick=%b want 0 0", running, tick);
    end
  endtask

  // Reset mid-RUN restores divisor 3; then count wraps after 300 ticks.
  task automatic test_reset_mid_run();
    idle_load(16'd7);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    cyc();
    reset = 1'b1; start = 1'b1; load = 1'b1; div_val = 16'd9;
    cyc();
    reset = 1'b0;
    idle_inputs();
    n_checks++;
    if (tick !== 1'b0 || running !== 1'b0 || load_ready !== 1'b1 || tick_count !== 8'd0) begin
      n_fails++;
      $display("FAIL midreset_outs: got tick=%b run=%b rdy=%b cnt=%0d want 0 0 1 0",
               tick, running, load_ready, tick_count);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      n_checks++;
      if (tick !== (k == 4)) begin
        n_fails++; $display("FAIL midreset_div c%0d: got %b want %b", k, tick, k == 4);
      end
      cyc();
    end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    idle_load(16'd0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    repeat (300) cyc();
    n_checks++;
    if (tick_count !== 8'd44) begin n_fails++; $display("FAIL wrap_count: got %0d want 44", tick_count); end
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

`ifdef TICK_GEN_CTRL_SQUARE_EN
  // Divisor 1: slow_clk period 4, cleared by reset.
  task automatic test_square();
    idle_load(16'd1);
    n_checks++;
    if (slow_clk !== 1'b0) begin n_fails++; $display("FAIL sq_idle: got %b want 0", slow_clk); end
    start = 1'b1;
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      n_checks++;
      if (slow_clk !== 1'(((k - 1) / 2) % 2)) begin
        n_fails++; $display("FAIL sq_wave c%0d: got %b want %0d", k, slow_clk, ((k - 1) / 2) % 2);
      end
      cyc();
    end
    cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    n_checks++;
    if (slow_clk !== 1'b0) begin n_fails++; $display("FAIL sq_reset: got %b want 0", slow_clk); end
  endtask
`endif

  initial begin
    reset = 1'b1;
    idle_inputs();
    div_val = '0;
    test_reset();
    test_default_run();
    test_div_zero();
    test_reload();
    test_stop_pending();
    test_start_stop();
    test_reset_mid_run();
`ifdef TICK_GEN_CTRL_SQUARE_EN
    test_square();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tick_gen_ctrl.md
TICK_GEN_CTRL -- requirements
Module: tick_gen_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 16, meaning the divide-counter and divisor width in bits.
REQ-002 SHALL have parameter DEFAULT_DIV, default 3, meaning the divisor loaded at reset.
REQ-003 SHALL have port clk  input  1  single system clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port start  input  1  request to enter RUN.
REQ-006 SHALL have port stop  input  1  request to return to IDLE.
REQ-007 SHALL have port load  input  1  divisor-load valid.
REQ-008 SHALL have port div_val  input  CNT_W  new divisor; tick period = div_val+1 cycles.
REQ-009 SHALL have port load_ready  output  1  divisor-load ready.
REQ-010 SHALL have port tick  output  1  one-cycle clock-enable strobe.
REQ-011 SHALL have port running  output  1  high while in RUN.
REQ-012 SHALL have port tick_count  output  8  count of ticks issued since the last start, wrapping modulo 256.

Function
REQ-013 SHALL implement FSM states IDLE and RUN; IDLE->RUN on start with no stop, and RUN->IDLE on stop.
REQ-014 SHALL give stop priority when start and stop are both high: state stays or becomes IDLE.
REQ-015 SHALL clear cnt to 0 on every state change and hold it at 0 in IDLE.
REQ-016 SHALL, in RUN, increment cnt each cycle and wrap it to 0 in the cycle after cnt==div_reg.
REQ-017 SHALL drive tick = (state==RUN && cnt==div_reg), decoded from registers only; tick is never high in IDLE.
REQ-018 SHALL, for start sampled at edge N, assert the first tick in cycle N+1+div_reg, with later ticks every div_reg+1 cycles.
REQ-019 SHALL assert tick every RUN cycle when div_reg==0.
REQ-020 SHALL drive load_ready high in IDLE; in RUN, load_ready is high unless a shadow divisor is pending.
REQ-021 SHALL, on load&&load_ready in IDLE, write div_val to div_reg at that edge.
REQ-022 SHALL, on load&&load_ready in RUN, capture div_val into a shadow register and set pending.
REQ-023 SHALL copy shadow to div_reg and clear pending on the edge where cnt wraps, so the new period starts exactly after a tick.
REQ-024 SHALL, on stop with pending set, apply the shadow value to div_reg and clear pending.
REQ-025 SHALL ignore load while load_ready is low, with no state change.
REQ-026 SHALL clear tick_count on start acceptance and increment it on every tick cycle, wrapping 255->0.
REQ-027 SHALL hold tick_count in IDLE.
REQ-028 SHALL drive running = (state==RUN).

Reset
REQ-029 SHALL, when reset is high at a clk edge, set state=IDLE, cnt=0, div_reg=DEFAULT_DIV, pending=0, tick_count=0, tick=0, running=0 and load_ready=1.
REQ-030 SHALL let reset override start, stop and load, including mid-RUN, with no tick in the following cycle.

Configuration
REQ-031 SHALL, with TICK_GEN_CTRL_SQUARE_EN defined, add output slow_clk (1 bit, reset 0) that toggles on every edge where tick is high, giving a 50%-duty square wave of period 2*(div_reg+1) cycles.
REQ-032 SHALL, without TICK_GEN_CTRL_SQUARE_EN, omit the slow_clk port and its register entirely.
REQ-033 SHALL use slow_clk only as data, never as a clock for other logic.

Structure
REQ-034 SHALL place the state enum (IDLE, RUN) and the default CNT_W/DEFAULT_DIV constants in the shared package tick_gen_pkg.
REQ-035 SHALL isolate cnt, its compare and its wrap in one sub-module, div_counter (inputs clk, reset, clr, en, limit; outputs wrap), instantiated once.

Verification
REQ-036 SHALL cover: reset, then start at cycle 0 with DEFAULT_DIV=3 -> tick in cycles 4, 8, 12; tick_count 1, 2, 3.
REQ-037 SHALL cover: IDLE load div_val=0, then start -> tick high every RUN cycle; stop -> tick low in the next cycle, running=0.
REQ-038 SHALL cover: RUN with div 3, load 1 at cnt=1 -> load_ready low until the next wrap; period 4 completes, then ticks every 2 cycles; a second load while low is ignored.
REQ-039 SHALL cover: start and stop high together in IDLE or RUN -> state IDLE, no tick.
REQ-040 SHALL cover: reset pulse mid-RUN at cnt=2 -> all outputs at reset values next cycle; div_reg=3 even if 7 was loaded; 300 ticks -> tick_count=44.
REQ-041 SHALL cover, with TICK_GEN_CTRL_SQUARE_EN and div 1: slow_clk toggles every 2 cycles (period 4); reset -> slow_clk=0.
